// File: rtl/microgreen_seq_pkg.sv
// Shared types and constants for the microgreen measurement sequencer.
package microgreen_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    VS_WAIT   = 3'd1,
    CAPTURE   = 3'd2,
    TRIG      = 3'd3,
    ECHO_WAIT = 3'd4,
    ECHO_MEAS = 3'd5,
    INFER     = 3'd6,
    DONE      = 3'd7
  } seq_state_t;

  localparam int unsigned ERR_CAM  = 0;
  localparam int unsigned ERR_ECHO = 1;
  localparam int unsigned ERR_BNN  = 2;

  localparam logic [15:0] ECHO_SAT = 16'hFFFF;

endpackage

// File: rtl/microgreen_seq_ctrl_sync_edge.sv
// Two-flop synchronizer with a third flop for rise/fall detection.
// Edge outputs appear two clk edges after the pin changes; the FSM acts on the third.
module sync_edge
  import microgreen_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sr;

  // shift the async pin through the synchronizer/edge chain
  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= {sr[1:0], din};
  end

  assign level = sr[1];
  assign rise  = sr[1] & ~sr[2];
  assign fall  = ~sr[1] & sr[2];

endmodule

// File: rtl/microgreen_seq_ctrl.sv
// Measurement sequencer: frame capture gating, ultrasonic ranging, BNN kick, result report.
// Optional feature: MICROGREEN_SEQ_AUTORUN_EN starts a cycle after PERIOD_CYCLES idle cycles.
module microgreen_seq_ctrl
  import microgreen_seq_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES   = 250,
  parameter int unsigned FRAME_TIMEOUT = 1250000,
  parameter int unsigned ECHO_TIMEOUT  = 750000,
  parameter int unsigned BNN_TIMEOUT   = 4096,
  parameter int unsigned WD_W          = 21,
  parameter int unsigned PERIOD_CYCLES = 2500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic        cam_pclk,
  input  logic        us_echo,
  input  logic        bnn_done,
  input  logic [1:0]  bnn_class,
  output logic        pix_strobe,
  output logic        frame_done,
  output logic        us_trig,
  output logic [15:0] echo_cycles,
  output logic        echo_valid,
  output logic        bnn_start,
  output logic [1:0]  result_class,
  output logic        result_valid,
  output logic [2:0]  err,
  output logic        busy
);

  seq_state_t state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] echo_d;
  logic [1:0]  cls_d;
  logic [2:0]  err_d;

  logic vs_lvl, vs_rise, vs_fall;
  logic href_lvl, href_rise, href_fall;
  logic pclk_lvl, pclk_rise, pclk_fall;
  logic echo_lvl, echo_rise, echo_fall;
  logic auto_go;

  sync_edge u_sync_vsync (.clk(clk), .rst(rst), .din(cam_vsync), .level(vs_lvl),   .rise(vs_rise),   .fall(vs_fall));
  sync_edge u_sync_href  (.clk(clk), .rst(rst), .din(cam_href),  .level(href_lvl), .rise(href_rise), .fall(href_fall));
  sync_edge u_sync_pclk  (.clk(clk), .rst(rst), .din(cam_pclk),  .level(pclk_lvl), .rise(pclk_rise), .fall(pclk_fall));
  sync_edge u_sync_echo  (.clk(clk), .rst(rst), .din(us_echo),   .level(echo_lvl), .rise(echo_rise), .fall(echo_fall));

  logic unused_edges;
  assign unused_edges = ^{vs_lvl, vs_fall, href_rise, href_fall, pclk_lvl, pclk_fall};

`ifdef MICROGREEN_SEQ_AUTORUN_EN
  logic [31:0] idle_q;

  // idle interval counter, restarts whenever the sequencer leaves IDLE
  always_ff @(posedge clk) begin
    if (rst || state_q != IDLE) idle_q <= '0;
    else                        idle_q <= idle_q + 32'd1;
  end

  assign auto_go = (state_q == IDLE) && (idle_q == 32'(PERIOD_CYCLES - 1));
`else
  assign auto_go = 1'b0;
`endif

  assign busy = (state_q != IDLE);

  // state, watchdog and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wd_q         <= '0;
      cnt_q        <= '0;
      echo_cycles  <= '0;
      result_class <= '0;
      err          <= '0;
    end else begin
      state_q      <= state_d;
      wd_q         <= wd_d;
      cnt_q        <= cnt_d;
      echo_cycles  <= echo_d;
      result_class <= cls_d;
      err          <= err_d;
    end
  end

  // next-state, register updates and strobe outputs
  always_comb begin
    state_d      = state_q;
    wd_d         = wd_q + 1'b1;
    cnt_d        = cnt_q;
    echo_d       = echo_cycles;
    cls_d        = result_class;
    err_d        = err;
    pix_strobe   = 1'b0;
    frame_done   = 1'b0;
    us_trig      = 1'b0;
    echo_valid   = 1'b0;
    bnn_start    = 1'b0;
    result_valid = 1'b0;

    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (start || auto_go) begin
          err_d   = '0;
          echo_d  = '0;
          cls_d   = '0;
          state_d = VS_WAIT;
        end
      end
      VS_WAIT: begin
        if (vs_rise) state_d = CAPTURE;
        else if (wd_q == WD_W'(FRAME_TIMEOUT - 1)) begin
          err_d[ERR_CAM] = 1'b1;
          state_d        = DONE;
        end
      end
      CAPTURE: begin
        pix_strobe = pclk_rise & href_lvl;
        if (vs_rise) begin
          frame_done = 1'b1;
          state_d    = TRIG;
        end else if (wd_q == WD_W'(FRAME_TIMEOUT - 1)) begin
          err_d[ERR_CAM] = 1'b1;
          state_d        = DONE;
        end
      end
      TRIG: begin
        us_trig = 1'b1;
        if (wd_q == WD_W'(TRIG_CYCLES - 1)) state_d = ECHO_WAIT;
      end
      ECHO_WAIT: begin
        if (echo_rise) begin
          cnt_d   = '0;
          state_d = ECHO_MEAS;
        end else if (wd_q == WD_W'(ECHO_TIMEOUT - 1)) begin
          echo_d          = ECHO_SAT;
          err_d[ERR_ECHO] = 1'b1;
          echo_valid      = 1'b1;
          state_d         = INFER;
        end
      end
      ECHO_MEAS: begin
        if (echo_fall) begin
          echo_d     = cnt_q;
          echo_valid = 1'b1;
          state_d    = INFER;
        end else if (cnt_q == ECHO_SAT) begin
          echo_d          = ECHO_SAT;
          err_d[ERR_ECHO] = 1'b1;
          echo_valid      = 1'b1;
          state_d         = INFER;
        end else if (echo_lvl) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      INFER: begin
        bnn_start = (wd_q == '0);
        if (bnn_done) begin
          cls_d   = bnn_class;
          state_d = DONE;
        end else if (wd_q == WD_W'(BNN_TIMEOUT - 1)) begin
          err_d[ERR_BNN] = 1'b1;
          cls_d          = '0;
          state_d        = DONE;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) wd_d = '0;
  end

endmodule

// File: tb/tb_microgreen_seq_ctrl.sv
// Directed bench for microgreen_seq_ctrl with reduced timeouts.
module tb_microgreen_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cam_vsync = 1'b0, cam_href = 1'b0, cam_pclk = 1'b0, us_echo = 1'b0;
  logic        bnn_done = 1'b0;
  logic [1:0]  bnn_class = 2'b00;
  logic        pix_strobe, frame_done, us_trig, echo_valid, bnn_start, result_valid, busy;
  logic [15:0] echo_cycles;
  logic [1:0]  result_class;
  logic [2:0]  err;

  microgreen_seq_ctrl #(
    .TRIG_CYCLES(10), .FRAME_TIMEOUT(2000), .ECHO_TIMEOUT(500), .BNN_TIMEOUT(50)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_pclk(cam_pclk), .us_echo(us_echo),
    .bnn_done(bnn_done), .bnn_class(bnn_class),
    .pix_strobe(pix_strobe), .frame_done(frame_done), .us_trig(us_trig),
    .echo_cycles(echo_cycles), .echo_valid(echo_valid), .bnn_start(bnn_start),
    .result_class(result_class), .result_valid(result_valid), .err(err), .busy(busy)
  );

  always #20 clk = ~clk;

  int n_total = 0, n_pass = 0;
  longint cyc = 0;
  int n_pix, n_fd, n_trig, n_ev, n_bs, n_rv;
  longint trig_last, ev_cyc, bs_cyc, rv_cyc, start_cyc;

  always @(posedge clk) cyc++;

  // pulse counters and event timestamps, sampled mid-cycle
  always @(negedge clk) begin
    if (pix_strobe)   n_pix++;
    if (frame_done)   n_fd++;
    if (us_trig)      begin n_trig++; trig_last = cyc; end
    if (echo_valid)   begin n_ev++;   ev_cyc = cyc;    end
    if (bnn_start)    begin n_bs++;   bs_cyc = cyc;    end
    if (result_valid) begin n_rv++;   rv_cyc = cyc;    end
  end

  typedef struct {
    string      name;
    bit         do_frame;
    int         echo_len;
    bit         do_bnn;
    logic [1:0] drive_cls;
    int         tcheck;
    int         exp_pix, exp_fd, exp_trig, exp_ev, exp_bs, exp_rv;
    logic [2:0] exp_err;
    logic [1:0] exp_cls;
    int         echo_lo, echo_hi;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_counts();
    n_pix = 0; n_fd = 0; n_trig = 0; n_ev = 0; n_bs = 0; n_rv = 0;
    trig_last = 0; ev_cyc = 0; bs_cyc = 0; rv_cyc = 0;
  endtask

  task automatic do_start();
    start = 1'b1; start_cyc = cyc;
    cyc_wait(1);
    start = 1'b0;
  endtask

  task automatic vs_pulse();
    cam_vsync = 1'b1; cyc_wait(4);
    cam_vsync = 1'b0; cyc_wait(4);
  endtask

  task automatic line();
    cam_href = 1'b1; cyc_wait(3);
    repeat (2) begin
      cam_pclk = 1'b1; cyc_wait(3);
      cam_pclk = 1'b0; cyc_wait(3);
    end
    cyc_wait(2);
    cam_href = 1'b0; cyc_wait(4);
  endtask

  task automatic wait_trig_done();
    int n = 0;
    while (!us_trig && n < 3000) begin @(negedge clk); n++; end
    chk("trig_rise_seen", us_trig, 1);
    n = 0;
    while (us_trig && n < 100) begin @(negedge clk); n++; end
    chk("trig_fall_seen", us_trig, 0);
  endtask

  task automatic echo_pulse(input int len);
    cyc_wait(5);
    us_echo = 1'b1; cyc_wait(len);
    us_echo = 1'b0;
  endtask

  task automatic wait_bs_and_respond(input bit respond, input logic [1:0] cls);
    int n = 0;
    while (!bnn_start && n < 1000) begin @(negedge clk); n++; end
    chk("bnn_start_seen", bnn_start, 1);
    if (respond) begin
      cyc_wait(3);
      bnn_done = 1'b1; bnn_class = cls;
      cyc_wait(1);
      bnn_done = 1'b0; bnn_class = 2'b00;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    chk("returned_idle", busy, 0);
  endtask

  task automatic run_vec(input vec_t v);
    clr_counts();
    do_start();
    if (v.do_frame) begin
      vs_pulse();
      repeat (10) line();
      vs_pulse();
      wait_trig_done();
      if (v.echo_len > 0) echo_pulse(v.echo_len);
      wait_bs_and_respond(v.do_bnn, v.drive_cls);
    end
    wait_idle();
    cyc_wait(2);
    chk({v.name, "_pix"},   n_pix,  v.exp_pix);
    chk({v.name, "_fdone"}, n_fd,   v.exp_fd);
    chk({v.name, "_trig"},  n_trig, v.exp_trig);
    chk({v.name, "_evld"},  n_ev,   v.exp_ev);
    chk({v.name, "_bst"},   n_bs,   v.exp_bs);
    chk({v.name, "_rvld"},  n_rv,   v.exp_rv);
    chk({v.name, "_err"},   err,    v.exp_err);
    chk({v.name, "_cls"},   result_class, v.exp_cls);
    chk_range({v.name, "_echo"}, echo_cycles, v.echo_lo, v.echo_hi);
    case (v.tcheck)
      1: chk({v.name, "_frame_to_lat"}, rv_cyc - start_cyc, 2001);
      2: chk({v.name, "_echo_to_lat"},  ev_cyc - trig_last, 500);
      3: chk({v.name, "_bnn_to_lat"},   rv_cyc - bs_cyc,    50);
      default: ;
    endcase
  endtask

  initial begin
    vecs[0] = '{"nominal",   1'b1, 15, 1'b1, 2'b10, 0, 20, 1, 10, 1, 1, 1, 3'b000, 2'b10, 14, 16};
    vecs[1] = '{"no_vsync",  1'b0,  0, 1'b0, 2'b00, 1,  0, 0,  0, 0, 0, 1, 3'b001, 2'b00, 0, 0};
    vecs[2] = '{"no_echo",   1'b1,  0, 1'b1, 2'b01, 2, 20, 1, 10, 1, 1, 1, 3'b010, 2'b01, 65535, 65535};
    vecs[3] = '{"bnn_tout",  1'b1, 15, 1'b0, 2'b00, 3, 20, 1, 10, 1, 1, 1, 3'b100, 2'b00, 14, 16};
    vecs[4] = '{"long_echo", 1'b1, 40, 1'b1, 2'b11, 0, 20, 1, 10, 1, 1, 1, 3'b000, 2'b11, 39, 41};

    clr_counts();
    cyc_wait(4);
    chk("reset_outputs",
        {pix_strobe, frame_done, us_trig, echo_cycles, echo_valid, bnn_start,
         result_class, result_valid, err, busy}, 0);
    rst = 1'b0;
    cyc_wait(3);
    chk("idle_not_busy", busy, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // href and pclk activity before the frame start must not strobe pixels
    clr_counts();
    do_start();
    cam_href = 1'b1;
    repeat (5) begin
      cam_pclk = 1'b1; cyc_wait(3);
      cam_pclk = 1'b0; cyc_wait(3);
    end
    chk("vswait_href_pix", n_pix, 0);
    chk("vswait_busy", busy, 1);
    cam_href = 1'b0;
    rst = 1'b1; cyc_wait(2); rst = 1'b0;
    chk("vswait_abort_idle", busy, 0);
    cyc_wait(3);

    // a second start during capture is dropped, not queued
    clr_counts();
    do_start();
    vs_pulse();
    repeat (5) line();
    do_start();
    repeat (5) line();
    vs_pulse();
    wait_trig_done();
    echo_pulse(15);
    wait_bs_and_respond(1'b1, 2'b01);
    wait_idle();
    cyc_wait(20);
    chk("midcap_rvld", n_rv, 1);
    chk("midcap_pix", n_pix, 20);
    chk("midcap_not_requeued", busy, 0);
    chk("midcap_cls", result_class, 2'b01);

    // reset while the trigger is high aborts immediately
    clr_counts();
    do_start();
    vs_pulse();
    repeat (2) line();
    vs_pulse();
    begin
      int n = 0;
      while (!us_trig && n < 3000) begin @(negedge clk); n++; end
    end
    chk("rsttrig_trig_seen", us_trig, 1);
    cyc_wait(3);
    rst = 1'b1;
    cyc_wait(1);
    chk("rsttrig_trig_low", us_trig, 0);
    chk("rsttrig_busy_low", busy, 0);
    rst = 1'b0;
    cyc_wait(100);
    chk("rsttrig_no_rvld", n_rv, 0);
    chk("rsttrig_no_bst", n_bs, 0);
    chk("rsttrig_err", err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #(40 * 200000);
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "global timeout");
  end

endmodule
